// File: rtl/sig_pkg.sv
// rtl/sig_pkg.sv - light encoding shared with the signal controller and debounce states
package sig_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } light_t;

  localparam logic [1:0] LIGHT_INVALID = 2'd3;

  typedef enum logic [1:0] {
    DEB_IDLE    = 2'd0,
    DEB_RISE    = 2'd1,
    DEB_PRESENT = 2'd2,
    DEB_FALL    = 2'd3
  } deb_state_t;

  function automatic logic is_green(input logic [1:0] code);
    return light_t'(code) == GREEN;
  endfunction

endpackage

// File: rtl/cntry_car_detector_if.sv
// rtl/cntry_car_detector_if.sv - loop/light inputs and queue status outputs of the detector
// CAR_DET_STATS_EN adds served_total.
interface cntry_car_detector_if #(
  parameter int CW = 4
);

  logic          loop_raw;
  logic [1:0]    cntry_sig;
  logic          car_req;
  logic [CW-1:0] car_count;
  logic          ovf_err;
  logic          sig_err;
`ifdef CAR_DET_STATS_EN
  logic [15:0]   served_total;

  modport master (
    output loop_raw, cntry_sig,
    input  car_req, car_count, ovf_err, sig_err, served_total
  );

  modport slave (
    input  loop_raw, cntry_sig,
    output car_req, car_count, ovf_err, sig_err, served_total
  );
`else
  modport master (
    output loop_raw, cntry_sig,
    input  car_req, car_count, ovf_err, sig_err
  );

  modport slave (
    input  loop_raw, cntry_sig,
    output car_req, car_count, ovf_err, sig_err
  );
`endif

endinterface

// File: rtl/loop_debounce.sv
// rtl/loop_debounce.sv - two-flop synchroniser and debounce FSM for the loop sensor
// Emits a one-cycle arrive pulse when the filtered level goes high.
module loop_debounce
  import sig_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic clock,
  input  logic clear_n,
  input  logic loop_raw,
  output logic arrive
);

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  logic [1:0] sync_q;
  logic       loop_s;
  deb_state_t state_q;
  logic [7:0] deb_cnt_q;

  assign loop_s = sync_q[1];

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      sync_q    <= 2'b00;
      state_q   <= DEB_IDLE;
      deb_cnt_q <= 8'd0;
      arrive    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], loop_raw};
      arrive <= 1'b0;
      case (state_q)
        DEB_IDLE: begin
          if (loop_s) begin
            // a single stable sample is already enough when DEB_CYCLES is 1
            if (DEB_CYCLES == 1) begin
              state_q <= DEB_PRESENT;
              arrive  <= 1'b1;
            end else begin
              state_q   <= DEB_RISE;
              deb_cnt_q <= 8'd1;
            end
          end
        end
        DEB_RISE: begin
          if (!loop_s) begin
            state_q <= DEB_IDLE;
          end else if (deb_cnt_q == DEB_LAST) begin
            state_q <= DEB_PRESENT;
            arrive  <= 1'b1;
          end else begin
            deb_cnt_q <= deb_cnt_q + 8'd1;
          end
        end
        DEB_PRESENT: begin
          if (!loop_s) begin
            if (DEB_CYCLES == 1) begin
              state_q <= DEB_IDLE;
            end else begin
              state_q   <= DEB_FALL;
              deb_cnt_q <= 8'd1;
            end
          end
        end
        DEB_FALL: begin
          if (loop_s) begin
            state_q <= DEB_PRESENT;
          end else if (deb_cnt_q == DEB_LAST) begin
            state_q <= DEB_IDLE;
          end else begin
            deb_cnt_q <= deb_cnt_q + 8'd1;
          end
        end
        default: state_q <= DEB_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cntry_car_detector.sv
// rtl/cntry_car_detector.sv - country-road car queue: pass timer, waiting count, request, error flags
// CAR_DET_STATS_EN adds the 16-bit served_total counter.
module cntry_car_detector
  import sig_pkg::*;
#(
  parameter int DEB_CYCLES  = 4,
  parameter int PASS_CYCLES = 8,
  parameter int CW          = 4
) (
  input logic                 clock,
  input logic                 clear_n,
  cntry_car_detector_if.slave det
);

  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [7:0]    PASS_LAST = 8'(PASS_CYCLES - 1);

  logic          arrive;
  logic          depart;
  logic          timer_run;
  logic [7:0]    pass_timer_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          ovf_set;
  logic          car_req_q;
  logic          ovf_q;
  logic          sig_err_q;

  loop_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_loop_debounce (
    .clock   (clock),
    .clear_n (clear_n),
    .loop_raw(det.loop_raw),
    .arrive  (arrive)
  );

  // depart is combinational so the decrement lands on the same edge the timer wraps
  assign timer_run = is_green(det.cntry_sig) && (count_q != '0);
  assign depart    = timer_run && (pass_timer_q == PASS_LAST);

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      pass_timer_q <= 8'd0;
    end else if (!timer_run || depart) begin
      pass_timer_q <= 8'd0;
    end else begin
      pass_timer_q <= pass_timer_q + 8'd1;
    end
  end

  always_comb begin
    count_d = count_q;
    ovf_set = 1'b0;
    case ({arrive, depart})
      2'b10: begin
        if (count_q == CNT_MAX) begin
          ovf_set = 1'b1;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      count_q   <= '0;
      car_req_q <= 1'b0;
      ovf_q     <= 1'b0;
      sig_err_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      car_req_q <= (count_d != '0);
      ovf_q     <= ovf_q | ovf_set;
      sig_err_q <= sig_err_q | (det.cntry_sig == LIGHT_INVALID);
    end
  end

  assign det.car_count = count_q;
  assign det.car_req   = car_req_q;
  assign det.ovf_err   = ovf_q;
  assign det.sig_err   = sig_err_q;

`ifdef CAR_DET_STATS_EN
  logic [15:0] served_q;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      served_q <= 16'd0;
    end else if (depart) begin
      served_q <= served_q + 16'd1;
    end
  end

  assign det.served_total = served_q;
`endif

endmodule

// File: tb/tb_cntry_car_detector.sv
// tb/tb_cntry_car_detector.sv - bench for cntry_car_detector against a run-length queue model
module tb_cntry_car_detector;
  import sig_pkg::*;

  localparam int DEB  = 4;
  localparam int PASS = 8;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic clock = 1'b0;
  logic clear_n = 1'b0;
  always #5 clock = ~clock;

  cntry_car_detector_if #(.CW(CW)) det ();

  cntry_car_detector #(
    .DEB_CYCLES (DEB),
    .PASS_CYCLES(PASS),
    .CW         (CW)
  ) dut (
    .clock  (clock),
    .clear_n(clear_n),
    .det    (det)
  );

  int n_checks = 0;
  int n_err    = 0;

  // reference model state
  int m_cnt;
  bit m_ovf;
  bit m_sigerr;
  int m_served;
  bit m_filt;
  int m_deb_run;
  bit m_arr;
  int m_green_run;
  bit raw_hist[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_ovf = 0; m_sigerr = 0; m_served = 0;
    m_filt = 0; m_deb_run = 0; m_arr = 0; m_green_run = 0;
    raw_hist.delete();
  endtask

  task automatic model_edge(input bit raw, input logic [1:0] sig);
    bit a, d, s;
    a = m_arr;
    // a car leaves after every PASS consecutive edges of GREEN with cars waiting
    if (sig == 2'd2 && m_cnt != 0) m_green_run++;
    else m_green_run = 0;
    d = (m_green_run != 0) && (m_green_run % PASS == 0);
    if (a && !d) begin
      if (m_cnt == MAXC) m_ovf = 1;
      else m_cnt++;
    end else if (d && !a) begin
      m_cnt--;
    end
    if (sig == 2'd3) m_sigerr = 1;
    if (d) m_served = (m_served + 1) % 65536;
    // the loop level seen this edge is the raw value from two edges earlier
    raw_hist.push_back(raw);
    if (raw_hist.size() > 3) void'(raw_hist.pop_front());
    s = (raw_hist.size() == 3) ? raw_hist[0] : 1'b0;
    m_arr = 0;
    if (s != m_filt) begin
      m_deb_run++;
      if (m_deb_run == DEB) begin
        m_filt = s;
        m_deb_run = 0;
        m_arr = s;
      end
    end else begin
      m_deb_run = 0;
    end
  endtask

  task automatic compare_model();
    check_val("count", det.car_count, m_cnt);
    check_val("car_req", det.car_req, (m_cnt != 0));
    check_val("ovf_err", det.ovf_err, m_ovf);
    check_val("sig_err", det.sig_err, m_sigerr);
`ifdef CAR_DET_STATS_EN
    check_val("served_total", det.served_total, m_served);
`endif
  endtask

  task automatic step(input bit raw, input logic [1:0] sig);
    det.loop_raw  = raw;
    det.cntry_sig = sig;
    @(posedge clock);
    model_edge(raw, sig);
    #1;
    compare_model();
  endtask

  task automatic car(input int hi, input int lo, input logic [1:0] sig);
    repeat (hi) step(1'b1, sig);
    repeat (lo) step(1'b0, sig);
  endtask

  task automatic async_reset();
    #3;
    clear_n = 1'b0;
    #1;
    check_val("rst_count", det.car_count, 0);
    check_val("rst_req", det.car_req, 0);
    check_val("rst_ovf", det.ovf_err, 0);
    check_val("rst_sig_err", det.sig_err, 0);
`ifdef CAR_DET_STATS_EN
    check_val("rst_served", det.served_total, 0);
`endif
    @(posedge clock);
    #1;
    clear_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bit         raw_cur;
    logic [1:0] sig_cur;
    int         raw_left;
    int         sig_left;
    int         r;

    det.loop_raw  = 1'b0;
    det.cntry_sig = RED;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_val("reset_count", det.car_count, 0);
    check_val("reset_req", det.car_req, 0);
    check_val("reset_ovf", det.ovf_err, 0);
    check_val("reset_sig_err", det.sig_err, 0);
    clear_n = 1'b1;

    // first car: count and request appear at edge 6
    for (int i = 0; i < 10; i++) begin
      step(1'b1, RED);
      if (i == 5) check_val("car1_early", det.car_count, 0);
      if (i == 6) begin
        check_val("car1_count", det.car_count, 1);
        check_val("car1_req", det.car_req, 1);
      end
    end
    repeat (10) step(1'b0, RED);
    car(3, 10, RED);
    check_val("glitch_ignored", det.car_count, 1);
    car(6, 2, RED);
    car(2, 10, RED);
    check_val("gap_one_car", det.car_count, 2);
    car(6, 6, RED);
    check_val("three_cars", det.car_count, 3);
    async_reset();

    // discharge of three cars
    repeat (3) car(6, 6, RED);
    check_val("queue3", det.car_count, 3);
    for (int i = 1; i <= 24; i++) begin
      step(1'b0, GREEN);
      if (i == 7)  check_val("drain_hold", det.car_count, 3);
      if (i == 8)  check_val("drain_8", det.car_count, 2);
      if (i == 16) check_val("drain_16", det.car_count, 1);
      if (i == 23) check_val("drain_req_hi", det.car_req, 1);
      if (i == 24) begin
        check_val("drain_24", det.car_count, 0);
        check_val("drain_req_lo", det.car_req, 0);
      end
    end

    // arrival on the same edge as a departure
    car(6, 6, RED);
    for (int i = 1; i <= 20; i++) begin
      step(i >= 2 && i < 10, GREEN);
      if (i == 8) begin
        check_val("coincide_count", det.car_count, 1);
        check_val("coincide_req", det.car_req, 1);
      end
      if (i == 16) check_val("coincide_drain", det.car_count, 0);
    end

    // saturation
    repeat (16) car(6, 6, RED);
    check_val("sat_count", det.car_count, MAXC);
    check_val("sat_ovf", det.ovf_err, 1);
    repeat (MAXC * PASS + 8) step(1'b0, GREEN);
    check_val("sat_drained", det.car_count, 0);
    check_val("sat_ovf_sticky", det.ovf_err, 1);

    // invalid light code mid-interval
    async_reset();
    repeat (2) car(6, 6, RED);
    repeat (5) step(1'b0, GREEN);
    step(1'b0, 2'd3);
    check_val("inv_sig_err", det.sig_err, 1);
    check_val("inv_count", det.car_count, 2);
    repeat (7) step(1'b0, GREEN);
    check_val("inv_timer_cleared", det.car_count, 2);
    repeat (13) step(1'b0, GREEN);
    check_val("inv_drained", det.car_count, 0);
`ifdef CAR_DET_STATS_EN
    check_val("served_two", det.served_total, 2);
`endif

    // reset mid-discharge
    repeat (2) car(6, 6, RED);
    repeat (4) step(1'b0, GREEN);
    async_reset();

    // randomized traffic
    raw_cur  = 1'b0;
    sig_cur  = RED;
    raw_left = 0;
    sig_left = 0;
    for (int n = 0; n < 3000; n++) begin
      if (raw_left == 0) begin
        raw_cur  = ~raw_cur;
        raw_left = $urandom_range(1, 9);
      end
      if (sig_left == 0) begin
        r = $urandom_range(0, 99);
        sig_cur  = (r < 40) ? 2'd0 : (r < 50) ? 2'd1 : (r < 97) ? 2'd2 : 2'd3;
        sig_left = (sig_cur == 2'd3) ? 1 : $urandom_range(5, 60);
      end
      step(raw_cur, sig_cur);
      raw_left--;
      sig_left--;
      if ($urandom_range(0, 799) == 0) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
